// File: rtl/shift_sub_divider.sv
// Restoring shift-subtract unsigned divider, 2N-bit dividend by N-bit divisor.
// Latency: 2N+1 cycles from the accepting edge to Done; divide-by-zero 1 cycle.
// Backpressure: Start is a held level; Done stays high until Start drops.
//
// Ports:
//   Clock, Reset       : rising-edge clock, synchronous active-high reset
//   Start              : level request, sampled only while idle
//   Dividend, Divisor  : operands, captured on the accepting edge only
//   Quotient, Remainder: registered result of the last completed operation
//   DivByZero          : registered, set when the last operation had Divisor = 0
//   Done               : registered completion flag
module shift_sub_divider #(
  parameter int N = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [2*N-1:0] Dividend,
  input  logic [N-1:0]   Divisor,
  output logic [2*N-1:0] Quotient,
  output logic [N-1:0]   Remainder,
  output logic           DivByZero,
  output logic           Done
);

  localparam int QW = 2 * N;
  localparam int RW = N + 1;
  localparam int CW = $clog2(QW) + 1;
  // The counter reaching 2N means every quotient bit has been produced.
  localparam logic [CW-1:0] LAST_CNT = CW'(QW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [RW-1:0] rem_reg;   // partial remainder
  logic [QW-1:0] quo_reg;   // dividend bits shift out the top, quotient bits in the bottom
  logic [N-1:0]  dvs_reg;   // divisor latched at accept
  logic [CW-1:0] cnt_reg;   // iterations completed

  logic [RW-1:0] shifted;
  logic [RW-1:0] trial;

  // One restoring step: bring the next dividend bit into the partial
  // remainder and try subtracting the divisor. The cast drops the top bit
  // of the old remainder, which is always zero because the remainder is
  // kept below the divisor between steps.
  always_comb begin
    shifted = RW'({rem_reg, quo_reg[QW-1]});
    trial   = shifted - {1'b0, dvs_reg};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            if (Divisor == '0) begin
              // No iterations needed: publish the saturated result at once.
              Quotient  <= '1;
              Remainder <= '0;
              DivByZero <= 1'b1;
              Done      <= 1'b1;
              state     <= DONE;
            end else begin
              quo_reg <= Dividend;
              rem_reg <= '0;
              dvs_reg <= Divisor;
              cnt_reg <= '0;
              state   <= WORK;
            end
          end
        end

        WORK: begin
          if (cnt_reg == LAST_CNT) begin
            // Outputs only move here, so they hold the previous result
            // for the whole of the working phase.
            Quotient  <= quo_reg;
            Remainder <= rem_reg[N-1:0];
            DivByZero <= 1'b0;
            Done      <= 1'b1;
            state     <= DONE;
          end else begin
            if (!trial[N]) begin
              rem_reg <= trial;
              quo_reg <= {quo_reg[QW-2:0], 1'b1};
            end else begin
              rem_reg <= shifted;
              quo_reg <= {quo_reg[QW-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DONE: begin
          // Hold the handshake until the requester lets go of Start.
          if (!Start) begin
            Done  <= 1'b0;
            state <= IDLE;
          end else begin
            Done <= 1'b1;
          end
        end

        default: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
